// File: rtl/bahis_giris.sv
// bahis_giris: keypad entry of a horse bet (horse 1-3, amount 1-127) presented downstream until accepted.
// Optional BAHIS_ZAMAN_ASIMI_EN adds a 255-cycle idle timeout in the entry states.
module bahis_giris (
  input  logic       saat,
  input  logic       reset,
  input  logic       tus_gecerli,
  input  logic [3:0] tus_kodu,
  input  logic       bahis_alindi,
  output logic [1:0] tahmin_edilen_at,
  output logic [6:0] yatirilan_para,
  output logic       bahis_gecerli,
  output logic       hata,
  output logic [7:0] bahis_sayisi
);
  typedef enum logic [1:0] {BOSTA, AT_SEC, PARA_GIR, SUNUM} state_t;
  state_t state, state_n;
  logic [1:0] at, at_n, hane, hane_n;
  logic [6:0] para, para_n;
  logic [10:0] yeni;
  logic hata_n, iptal, onay, yasak, zaman_asimi;
  assign iptal = tus_kodu == 4'd10;
  assign onay = tus_kodu == 4'd11;
  assign yasak = tus_kodu >= 4'd12;
  assign yeni = {4'd0, para} * 11'd10 + {7'd0, tus_kodu};
`ifdef BAHIS_ZAMAN_ASIMI_EN
  logic [7:0] bekle;
  logic giris;
  assign giris = state == AT_SEC || state == PARA_GIR;
  assign zaman_asimi = giris && !tus_gecerli && bekle == 8'd254;
  // idle cycles since entering the state or since the last strobe
  always_ff @(posedge saat or negedge reset)
    if (!reset) bekle <= 8'd0;
    else bekle <= (!giris || tus_gecerli || state_n != state) ? 8'd0 : bekle + 8'd1;
`else
  assign zaman_asimi = 1'b0;
`endif
  always_comb begin
    state_n = state;
    at_n = at;
    para_n = para;
    hane_n = hane;
    hata_n = 1'b0;
    if (zaman_asimi) begin
      state_n = BOSTA;
      at_n = 2'd0;
      para_n = 7'd0;
      hane_n = 2'd0;
      hata_n = 1'b1;
    end else if (state == SUNUM) begin
      if (bahis_alindi) begin
        state_n = BOSTA;
        at_n = 2'd0;
        para_n = 7'd0;
      end
    end else if (tus_gecerli) begin
      if (yasak) hata_n = 1'b1;
      else if (state == BOSTA) state_n = AT_SEC;
      else if (iptal) begin
        state_n = BOSTA;
        at_n = 2'd0;
        para_n = 7'd0;
        hane_n = 2'd0;
      end else if (state == AT_SEC) begin
        if (tus_kodu >= 4'd1 && tus_kodu <= 4'd3) begin
          state_n = PARA_GIR;
          at_n = tus_kodu[1:0];
          para_n = 7'd0;
          hane_n = 2'd0;
        end else hata_n = 1'b1;
      end else if (onay) begin
        if (para == 7'd0) hata_n = 1'b1;
        else state_n = SUNUM;
      end else if (hane == 2'd3 || yeni > 11'd127) begin
        // a fourth digit always overflows, whatever its value
        state_n = BOSTA;
        at_n = 2'd0;
        para_n = 7'd0;
        hane_n = 2'd0;
        hata_n = 1'b1;
      end else begin
        para_n = yeni[6:0];
        hane_n = hane + 2'd1;
      end
    end
  end
  always_ff @(posedge saat or negedge reset)
    if (!reset) begin
      state <= BOSTA;
      at <= 2'd0;
      para <= 7'd0;
      hane <= 2'd0;
      hata <= 1'b0;
      bahis_sayisi <= 8'd0;
    end else begin
      state <= state_n;
      at <= at_n;
      para <= para_n;
      hane <= hane_n;
      hata <= hata_n;
      if (state == SUNUM && bahis_alindi) bahis_sayisi <= bahis_sayisi + 8'd1;
    end
  assign bahis_gecerli = state == SUNUM;
  assign tahmin_edilen_at = bahis_gecerli ? at : 2'd0;
  assign yatirilan_para = bahis_gecerli ? para : 7'd0;
endmodule

// File: tb/tb_bahis_giris.sv
// tb_bahis_giris: directed and random key sequences checked against a behavioural bet-entry model.
module tb_bahis_giris;
  logic saat = 1'b0, reset = 1'b0, tus_gecerli = 1'b0, bahis_alindi = 1'b0;
  logic [3:0] tus_kodu = 4'd0;
  logic [1:0] tahmin_edilen_at;
  logic [6:0] yatirilan_para;
  logic bahis_gecerli, hata;
  logic [7:0] bahis_sayisi;
  int n_test = 0, n_fail = 0;
  int mst, horse, amount, ndig, cnt, idle, eh;
  always #5 saat = ~saat;
  bahis_giris dut (
    .saat(saat),
    .reset(reset),
    .tus_gecerli(tus_gecerli),
    .tus_kodu(tus_kodu),
    .bahis_alindi(bahis_alindi),
    .tahmin_edilen_at(tahmin_edilen_at),
    .yatirilan_para(yatirilan_para),
    .bahis_gecerli(bahis_gecerli),
    .hata(hata),
    .bahis_sayisi(bahis_sayisi)
  );
  task automatic chk(string tag, int got, int exp);
    n_test++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    mst = 0;
    horse = 0;
    amount = 0;
    ndig = 0;
    cnt = 0;
    idle = 0;
    eh = 0;
  endtask
  task automatic check_all();
    chk("gecerli", bahis_gecerli, mst == 3);
    chk("at", tahmin_edilen_at, mst == 3 ? horse : 0);
    chk("para", yatirilan_para, mst == 3 ? amount : 0);
    chk("hata", hata, eh);
    chk("sayi", bahis_sayisi, cnt);
  endtask
  // mode: 0 idle, 1 choosing horse, 2 entering amount, 3 presenting
  task automatic step(bit v, int k, bit a);
    int prev, nv;
    bit to;
    tus_gecerli = v;
    tus_kodu = 4'(k);
    bahis_alindi = a;
    @(posedge saat);
    prev = mst;
    eh = 0;
    to = 0;
`ifdef BAHIS_ZAMAN_ASIMI_EN
    to = (mst == 1 || mst == 2) && !v && idle == 254;
`endif
    if (to) begin
      eh = 1; mst = 0; horse = 0; amount = 0;
    end else if (mst == 3) begin
      if (a) begin cnt = (cnt + 1) % 256; mst = 0; end
    end else if (v) begin
      if (k >= 12) eh = 1;
      else if (mst == 0) mst = 1;
      else if (k == 10) begin mst = 0; horse = 0; amount = 0; end
      else if (mst == 1) begin
        if (k >= 1 && k <= 3) begin horse = k; amount = 0; ndig = 0; mst = 2; end
        else eh = 1;
      end else if (k == 11) begin
        if (amount == 0) eh = 1;
        else mst = 3;
      end else begin
        nv = amount * 10 + k;
        if (ndig == 3 || nv > 127) begin eh = 1; mst = 0; horse = 0; amount = 0; end
        else begin amount = nv; ndig++; end
      end
    end
    idle = ((mst == 1 || mst == 2) && mst == prev && !v) ? idle + 1 : 0;
    #1;
    tus_gecerli = 1'b0;
    bahis_alindi = 1'b0;
    check_all();
  endtask
  task automatic keys(int ks[$]);
    foreach (ks[i]) step(1'b1, ks[i], 1'b0);
  endtask
  initial begin
    model_reset();
    #12;
    check_all();
    reset = 1'b1;
    keys('{7, 2, 5, 5, 11});
    chk("r35_at", tahmin_edilen_at, 2);
    chk("r35_para", yatirilan_para, 55);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    chk("r35_held", bahis_gecerli, 1);
    step(1'b0, 0, 1'b1);
    chk("r35_sayi", bahis_sayisi, 1);
    chk("r35_clr", yatirilan_para, 0);
    keys('{0, 1, 1, 2, 8});
    chk("r36_hata", hata, 1);
    step(1'b0, 0, 1'b0);
    chk("r36_pulse", hata, 0);
    keys('{10, 3, 1, 2, 7, 11});
    chk("r37_at", tahmin_edilen_at, 3);
    chk("r37_para", yatirilan_para, 127);
    keys('{10, 14, 5});
    chk("r21_ignore", bahis_gecerli, 1);
    chk("r21_nohata", hata, 0);
    step(1'b0, 0, 1'b1);
    keys('{11, 4});
    chk("r38_hata4", hata, 1);
    keys('{1, 0, 11});
    chk("r38_hata0", hata, 1);
    keys('{9, 10});
    chk("r38_iptal", hata, 0);
    keys('{5, 2});
`ifdef BAHIS_ZAMAN_ASIMI_EN
    repeat (254) step(1'b0, 0, 1'b0);
    chk("r40_wait", hata, 0);
    step(1'b0, 0, 1'b0);
    chk("r40_timeout", hata, 1);
`else
    repeat (1000) step(1'b0, 0, 1'b0);
    keys('{5, 11});
    chk("r40_at", tahmin_edilen_at, 2);
    chk("r40_para", yatirilan_para, 5);
    step(1'b0, 0, 1'b1);
`endif
    repeat (3000) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) step(1'b1, r == 0 ? $urandom_range(10, 15) : $urandom_range(0, 11), $urandom_range(0, 3) == 0);
      else step(1'b0, 0, $urandom_range(0, 3) == 0);
    end
    @(negedge saat);
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge saat);
    reset = 1'b1;
    repeat (256) begin
      keys('{3, 1, 1, 11});
      step(1'b0, 0, 1'b1);
    end
    chk("r39_wrap", bahis_sayisi, 0);
    keys('{3, 1, 1, 11});
    chk("r39_pre", bahis_gecerli, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("r39_async", bahis_gecerli, 0);
    model_reset();
    check_all();
    @(negedge saat);
    reset = 1'b1;
    keys('{6});
    keys('{2});
    chk("r31_first", hata, 0);
    keys('{4, 11});
    chk("r31_bet", yatirilan_para, 4);
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule

// File: doc/bahis_giris.md
BAHIS_GIRIS -- requirements
Module: bahis_giris

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 saat  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 tus_gecerli  input  1  keypad strobe; one saat cycle per key press.
REQ-005 tus_kodu  input  4  key code: 0-9 digit, 10 IPTAL (cancel), 11 ONAY (confirm), 12-15 illegal.
REQ-006 bahis_alindi  input  1  downstream betting stage accepts the presented bet.
REQ-007 tahmin_edilen_at  output  2  selected horse: 1 beyaz, 2 siyah, 3 boz; 0 = no bet presented.
REQ-008 yatirilan_para  output  7  bet amount, unsigned, 1-127.
REQ-009 bahis_gecerli  output  1  tahmin_edilen_at and yatirilan_para are valid and held.
REQ-010 hata  output  1  one-cycle error pulse.
REQ-011 bahis_sayisi  output  8  count of accepted bets, wraps 255 -> 0.

Function
REQ-012 The FSM SHALL have states BOSTA, AT_SEC, PARA_GIR, SUNUM.
REQ-013 BOSTA: any key strobe SHALL move to AT_SEC and not be consumed as data.
REQ-014 AT_SEC: digit 1-3 SHALL latch horse and go to PARA_GIR with amount 0; digit 0 or 4-9 SHALL pulse hata and stay.
REQ-015 PARA_GIR: digit d SHALL set amount = amount*10 + d, computed at 11 bits.
REQ-016 If the new amount exceeds 127, PARA_GIR SHALL pulse hata, clear horse and amount, and go to BOSTA.
REQ-017 A fourth digit SHALL be treated as overflow per REQ-016, whatever its value.
REQ-018 ONAY with amount 0 SHALL pulse hata and stay in PARA_GIR.
REQ-019 ONAY with amount 1-127 SHALL go to SUNUM.
REQ-020 In SUNUM, bahis_gecerli SHALL be 1 from the cycle after the ONAY strobe, with outputs stable.
REQ-021 In SUNUM, the block SHALL ignore all key strobes, including IPTAL.
REQ-022 SUNUM with bahis_alindi=1 on an edge SHALL increment bahis_sayisi, clear all outputs to 0 the next cycle, and go to BOSTA.
REQ-023 bahis_alindi SHALL be ignored outside SUNUM.
REQ-024 IPTAL in AT_SEC or PARA_GIR SHALL clear horse and amount and go to BOSTA, with no hata.
REQ-025 Illegal codes 12-15 SHALL pulse hata and cause no state change, in all states except SUNUM.
REQ-026 ONAY in AT_SEC SHALL pulse hata with no state change.
REQ-027 Outside SUNUM, tahmin_edilen_at and yatirilan_para SHALL read 0; the partial amount stays internal.
REQ-028 hata SHALL assert in the cycle after the offending strobe, for exactly one cycle.

Reset
REQ-029 reset=0 SHALL asynchronously force BOSTA and all outputs to 0, including bahis_sayisi.
REQ-030 Reset during SUNUM SHALL drop bahis_gecerli without counting the bet.
REQ-031 After reset release, the first strobe SHALL be evaluated on the first rising edge with reset=1.

Configuration
REQ-032 With BAHIS_ZAMAN_ASIMI_EN defined, an 8-bit idle counter SHALL run in AT_SEC and PARA_GIR and reload on every key strobe.
REQ-033 When that counter reaches 255 cycles without a strobe, the block SHALL pulse hata, clear the entry, and return to BOSTA.
REQ-034 Without BAHIS_ZAMAN_ASIMI_EN, no counter logic SHALL exist, and AT_SEC and PARA_GIR SHALL wait indefinitely.

Verification
REQ-035 Keys any,2,5,5,ONAY, then bahis_alindi=1 after 3 cycles -> outputs 2/55, bahis_gecerli held 3 cycles, bahis_sayisi=1, outputs 0 afterwards.
REQ-036 Keys any,1,1,2,8 -> hata pulse one cycle after the 8, state BOSTA, outputs 0.
REQ-037 Keys any,3,1,2,7,ONAY -> tahmin_edilen_at=3, yatirilan_para=127, bahis_gecerli=1.
REQ-038 Keys any,4 -> hata; then 1,0,ONAY -> hata, state stays PARA_GIR; then 9,IPTAL -> BOSTA with no hata.
REQ-039 Accept 256 bets of 1/1 -> bahis_sayisi reads 0; reset=0 mid-SUNUM -> bahis_gecerli falls with no clock edge.
REQ-040 With BAHIS_ZAMAN_ASIMI_EN: keys any,2, then 255 idle cycles -> hata, state BOSTA; without the macro -> still AT_SEC... PARA_GIR after 1000 cycles.
